// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one 16-bit ALU
//
// Purpose: accepts one operation at a time from requester A or B, executes
// it on a single shared combinational ALU and returns a tagged result
// through a valid/ready response port.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_ready/a_op/a_lhs/a_rhs   requester A operation channel
//   b_valid/b_ready/b_op/b_lhs/b_rhs   requester B operation channel
//   rsp_valid/rsp_ready         response handshake
//   rsp_id                      result owner (0 = A, 1 = B)
//   rsp_data                    16-bit result
//   busy                        high while an operation is in flight
//   ops_done                    wrapping count of delivered responses

module alu16 (
  input  logic [2:0]  op_i,
  input  logic [15:0] lhs_i,
  input  logic [15:0] rhs_i,
  output logic [15:0] res_o
);

  always_comb begin
    res_o = 16'h0000;
    case (op_i)
      3'b000:  res_o = 16'h0000;
      3'b001:  res_o = lhs_i + rhs_i;
      3'b010:  res_o = lhs_i - rhs_i;
      3'b011:  res_o = lhs_i & rhs_i;
      3'b100:  res_o = lhs_i | rhs_i;
      3'b101:  res_o = lhs_i ^ rhs_i;
      3'b110:  res_o = lhs_i;
      default: res_o = rhs_i;
    endcase
  end

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_op,
  input  logic [15:0] a_lhs,
  input  logic [15:0] a_rhs,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_op,
  input  logic [15:0] b_lhs,
  input  logic [15:0] b_rhs,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;          // requester served last: 0 = A, 1 = B
  logic [2:0]  op_q, op_d;
  logic [15:0] lhs_q, lhs_d;
  logic [15:0] rhs_q, rhs_d;
  logic        id_q, id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] ops_done_q, ops_done_d;

  logic        a_pick, b_pick;
  logic        a_hs, b_hs;
  logic [15:0] alu_res;

  // The shared ALU only ever sees the captured operands, so later changes
  // on the request inputs cannot disturb an operation in flight.
  alu16 u_alu (
    .op_i  (op_q),
    .lhs_i (lhs_q),
    .rhs_i (rhs_q),
    .res_o (alu_res)
  );

  // Round-robin pick: a lone requester always wins; under contention the
  // one not served last wins. Exactly one of a_pick/b_pick can be high.
  always_comb begin
    a_pick = a_valid && (!b_valid || last_q);
    b_pick = b_valid && (!a_valid || !last_q);
  end

  // Ready is gated by rst so nothing looks accepted during a reset cycle.
  always_comb begin
    a_ready = (state_q == IDLE) && !rst && a_pick;
    b_ready = (state_q == IDLE) && !rst && b_pick;
    a_hs    = a_valid && a_ready;
    b_hs    = b_valid && b_ready;
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_d       = op_q;
    lhs_d      = lhs_q;
    rhs_d      = rhs_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    ops_done_d = ops_done_q;

    unique case (state_q)
      IDLE: begin
        if (a_hs) begin
          op_d    = a_op;
          lhs_d   = a_lhs;
          rhs_d   = a_rhs;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = EXEC;
        end else if (b_hs) begin
          op_d    = b_op;
          lhs_d   = b_lhs;
          rhs_d   = b_rhs;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_res;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        // Returning to IDLE (rather than accepting here) keeps a one-cycle
        // gap between a response handshake and the next acceptance.
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      op_q       <= 3'b000;
      lhs_q      <= 16'h0000;
      rhs_q      <= 16'h0000;
      id_q       <= 1'b0;
      rsp_data_q <= 16'h0000;
      rsp_id_q   <= 1'b0;
      ops_done_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      op_q       <= op_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      ops_done_q <= ops_done_d;
    end
  end

  always_comb begin
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    ops_done  = ops_done_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [2:0]  a_op;
  logic [15:0] a_lhs, a_rhs;
  logic        b_valid, b_ready;
  logic [2:0]  b_op;
  logic [15:0] b_lhs, b_rhs;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data, ops_done;
  logic        busy;

  alu_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_op      (a_op),
    .a_lhs     (a_lhs),
    .a_rhs     (a_rhs),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_op      (b_op),
    .b_lhs     (b_lhs),
    .b_rhs     (b_rhs),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_count = 0;
  logic [15:0] exp_ops = 16'h0000;
  logic [15:0] a_exp = 16'h0000;
  logic [15:0] b_exp = 16'h0000;
  bit          contend = 1'b0;
  bit          cont_next = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Acceptance watcher: pushes the hand-computed result for each handshake.
  always @(negedge clk) begin
    if (rst) begin
      cont_next = 1'b0;
    end else begin
      if (a_valid && a_ready) begin
        sb_q.push_back('{1'b0, a_exp, cyc});
        acc_count++;
        if (contend) begin
          chk1("grant_order", 1'b0, cont_next);
          cont_next = ~cont_next;
        end
      end
      if (b_valid && b_ready) begin
        sb_q.push_back('{1'b1, b_exp, cyc});
        acc_count++;
        if (contend) begin
          chk1("grant_order", 1'b1, cont_next);
          cont_next = ~cont_next;
        end
      end
    end
  end

  // Response monitor: pops and compares, checks hold, latency and counter.
  logic        prev_valid = 1'b0;
  logic        ops_pend = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  logic        prev_id = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_ops    = 16'h0000;
      prev_valid = 1'b0;
      ops_pend   = 1'b0;
    end else begin
      chk1("ready_exclusive", a_ready && b_ready, 1'b0);
      if (busy) chk1("ready_while_busy", a_ready || b_ready, 1'b0);
      if (ops_pend) begin
        chk16("ops_done", ops_done, exp_ops);
        chk1("rsp_valid_drop", rsp_valid, 1'b0);
        ops_pend = 1'b0;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %b data %h expected no response", rsp_id, rsp_data);
        end else begin
          if (!prev_valid) begin
            chk32("latency", cyc - sb_q[0].acc, 2);
          end else begin
            chk16("hold_data", rsp_data, prev_data);
            chk1("hold_id", rsp_id, prev_id);
          end
          if (rsp_ready) begin
            chk16("rsp_data", rsp_data, sb_q[0].data);
            chk1("rsp_id", rsp_id, sb_q[0].id);
            void'(sb_q.pop_front());
            exp_ops  = exp_ops + 16'd1;
            ops_pend = 1'b1;
          end
        end
      end
      prev_valid = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_id    = rsp_id;
    end
  end

  task automatic issue(input bit id, input logic [2:0] op, input logic [15:0] l,
                       input logic [15:0] r, input logic [15:0] e);
    int start;
    start = acc_count;
    if (!id) begin
      a_op = op; a_lhs = l; a_rhs = r; a_exp = e; a_valid = 1'b1;
    end else begin
      b_op = op; b_lhs = l; b_rhs = r; b_exp = e; b_valid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (acc_count != start) break;
    end
    if (acc_count == start) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no handshake expected one for requester %0d", id);
    end
    #1;
    // Scramble the request after acceptance; the result must not change.
    if (!id) begin
      a_valid = 1'b0; a_op = 3'($urandom); a_lhs = 16'($urandom); a_rhs = 16'($urandom);
    end else begin
      b_valid = 1'b0; b_op = 3'($urandom); b_lhs = 16'($urandom); b_rhs = 16'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    a_valid = 1'b1; a_op = 3'b110; a_lhs = 16'h1111; a_rhs = 16'hDEAD; a_exp = 16'h1111;
    b_valid = 1'b1; b_op = 3'b111; b_lhs = 16'hBEEF; b_rhs = 16'h2222; b_exp = 16'h2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_a_ready", a_ready, 1'b0);
    chk1("rst_b_ready", b_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_ops_done", ops_done, 16'h0000);
    chk16("rst_rsp_data", rsp_data, 16'h0000);
    chk1("rst_rsp_id", rsp_id, 1'b0);

    // Contention straight out of reset: A first, then strict alternation.
    contend = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acc_count >= 4) break;
      @(posedge clk);
    end
    if (acc_count < 4) begin
      checks++;
      errors++;
      $display("FAIL contention_timeout: got %0d accepts expected 4", acc_count);
    end
    #1;
    a_valid = 1'b0; b_valid = 1'b0; contend = 1'b0;
    drain();
    chk16("ops_after_contention", ops_done, 16'd4);

    // Single op: 3 + 4.
    issue(1'b0, 3'b001, 16'h0003, 16'h0004, 16'h0007);
    drain();
    chk16("ops_after_single", ops_done, 16'd5);

    // Add wrap and subtract borrow on B.
    issue(1'b1, 3'b001, 16'hFFFF, 16'h0002, 16'h0001);
    issue(1'b1, 3'b010, 16'h0000, 16'h0001, 16'hFFFF);
    drain();

    // Backpressure: A result held 5 RESP cycles while B waits.
    rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 16'hF0F0, 16'h3C3C, 16'h3030);
    b_op = 3'b100; b_lhs = 16'h1200; b_rhs = 16'h0034; b_exp = 16'h1234; b_valid = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk1("bp_b_ready_low", b_ready, 1'b0);
    chk1("bp_rsp_valid", rsp_valid, 1'b1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (acc_count >= 9) break;
      @(posedge clk);
    end
    #1 b_valid = 1'b0;
    drain();
    chk16("ops_after_bp", ops_done, 16'd9);
    b_exp = 16'h0000;
    chk1("bp_all_accepted", acc_count == 9, 1'b1);

    // Reset while in EXEC discards the operation.
    issue(1'b0, 3'b101, 16'h00FF, 16'h0F0F, 16'h0FF0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_rsp_valid", rsp_valid, 1'b0);
    chk16("midrst_ops_done", ops_done, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 3'b101, 16'h00FF, 16'h0F0F, 16'h0FF0);
    drain();
    chk16("ops_after_reissue", ops_done, 16'd1);

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge clk);
    force dut.ops_done_q = 16'hFFFF;
    #1 release dut.ops_done_q;
    exp_ops = 16'hFFFF;
    @(negedge clk);
    chk16("ops_preload", ops_done, 16'hFFFF);
    @(posedge clk);
    #1;
    issue(1'b1, 3'b000, 16'h1234, 16'h5678, 16'h0000);
    drain();
    chk16("ops_wrap", ops_done, 16'h0000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
